// File: rtl/event_sched_pkg.sv
// event_sched_pkg: shared types and helpers for event_arbiter_scheduler.
// Holds the scheduler state encoding, a constant-friendly clog2, the display
// code width derivation and the round-robin search used by the arbiter.
package event_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Widest pending vector supported (14 sensors + heater + cooler).
    localparam int unsigned MAX_VEC = 16;
    localparam int unsigned IDX_W   = 4;

    // Smallest r such that 2**r >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Display carries index+1 for NUM_CH+2 channels plus the "none" code 0.
    function automatic int unsigned code_width(input int unsigned num_ch);
        return clog2(num_ch + 3);
    endfunction

    // First set bit strictly after start, wrapping from n-1 to 0.
    // With start = n-1 this degenerates to the lowest set index.
    function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_VEC-1:0] vec,
                                                 input int unsigned     n,
                                                 input int unsigned     start);
        logic [IDX_W-1:0] idx;
        logic             found;
        int unsigned      pos;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_VEC; k++) begin
            pos = start + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if (!found && (k <= n) && vec[pos[IDX_W-1:0]]) begin
                idx   = pos[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/temp_hysteresis.sv
// temp_hysteresis: registered heater/cooler requests with a hysteresis band
// around each threshold. Disabling the sensor clears both requests.
module temp_hysteresis
    import event_sched_pkg::*;
#(
    parameter int unsigned TEMP_W    = 6,
    parameter int unsigned TEMP_LOW  = 8,
    parameter int unsigned TEMP_HIGH = 30,
    parameter int unsigned HYST      = 2
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              temp_en,
    input  logic [TEMP_W-1:0] temperature,
    output logic              heat_req,
    output logic              cool_req
);

    localparam logic [TEMP_W-1:0] HEAT_ON  = TEMP_W'(TEMP_LOW);
    localparam logic [TEMP_W-1:0] HEAT_OFF = TEMP_W'(TEMP_LOW + HYST);
    localparam logic [TEMP_W-1:0] COOL_ON  = TEMP_W'(TEMP_HIGH);
    localparam logic [TEMP_W-1:0] COOL_OFF = TEMP_W'(TEMP_HIGH - HYST);

    // Set/clear/hold each request; inside the band the previous value holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            heat_req <= 1'b0;
            cool_req <= 1'b0;
        end else begin
            if (!temp_en || temperature >= HEAT_OFF) begin
                heat_req <= 1'b0;
            end else if (temperature <= HEAT_ON) begin
                heat_req <= 1'b1;
            end

            if (!temp_en || temperature <= COOL_OFF) begin
                cool_req <= 1'b0;
            end else if (temperature >= COOL_ON) begin
                cool_req <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_arbiter_scheduler.sv
// event_arbiter_scheduler: arbitrates NUM_CH level sensor requests plus the
// heater/cooler requests, holds each grant for DWELL_CYCLES and then forces a
// single all-off cycle before the next grant (break-before-make).
// Optional macro PREEMPT_EN: in fixed-priority mode, a pending request with a
// lower index than the one being served aborts the dwell.
module event_arbiter_scheduler
    import event_sched_pkg::*;
#(
    parameter int unsigned NUM_CH       = 5,
    parameter int unsigned TEMP_W       = 6,
    parameter int unsigned TEMP_LOW     = 8,
    parameter int unsigned TEMP_HIGH    = 30,
    parameter int unsigned HYST         = 2,
    parameter int unsigned DWELL_CYCLES = 4,
    localparam int unsigned N           = NUM_CH + 2,
    localparam int unsigned CODE_W      = code_width(NUM_CH)
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              temp_en,
    input  logic [TEMP_W-1:0] temperature,
    input  logic              rr_mode,
    output logic [N-1:0]      grant,
    output logic [CODE_W-1:0] display,
    output logic              busy
);

    localparam int unsigned       CNT_W    = (DWELL_CYCLES > 1) ? clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_CH + 1);
    localparam logic [MAX_VEC-1:0] ONE_V   = MAX_VEC'(1);

    state_t              state_q, state_d;
    logic                heat_req, cool_req;
    logic [N-1:0]        pend;
    logic [MAX_VEC-1:0]  pend_ext;
    logic [MAX_VEC-1:0]  win_onehot;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N-1:0]        grant_d;
    logic [CODE_W-1:0]   display_d;
    logic                busy_d;
    logic                arbitrate;
    logic                preempt;

    temp_hysteresis #(
        .TEMP_W    (TEMP_W),
        .TEMP_LOW  (TEMP_LOW),
        .TEMP_HIGH (TEMP_HIGH),
        .HYST      (HYST)
    ) u_temp (
        .clk         (clk),
        .reset_n     (reset_n),
        .temp_en     (temp_en),
        .temperature (temperature),
        .heat_req    (heat_req),
        .cool_req    (cool_req)
    );

    assign pend = {cool_req, heat_req, req};

    // Zero-extend the pending vector to the width the package helpers expect.
    always_comb begin
        pend_ext        = '0;
        pend_ext[N-1:0] = pend;
    end

    // Fixed priority is the round-robin search started from the top index.
    assign win        = rr_mode ? rr_next(pend_ext, N, {{(32-IDX_W){1'b0}}, last_q})
                                : rr_next(pend_ext, N, N - 1);
    assign win_onehot = ONE_V << win;

`ifdef PREEMPT_EN
    logic [MAX_VEC-1:0] lower_mask;
    assign lower_mask = (ONE_V << last_q) - ONE_V;
    assign preempt    = !rr_mode && ((pend_ext & lower_mask) != '0);
`else
    assign preempt    = 1'b0;
`endif

    // Next-state and next-output logic; last_q names the channel being served.
    // GAP is the single all-off cycle, so arbitration happens on its exit edge.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        display_d = display;
        busy_d    = busy;
        cnt_d     = cnt_q;
        last_d    = last_q;
        arbitrate = 1'b0;

        case (state_q)
            IDLE: arbitrate = 1'b1;
            SERVE: begin
                if (!pend_ext[last_q] || (cnt_q == '0) || preempt) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    display_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP:  arbitrate = 1'b1;
            default: begin
                state_d   = IDLE;
                grant_d   = '0;
                display_d = '0;
                busy_d    = 1'b0;
            end
        endcase

        if (arbitrate) begin
            state_d   = IDLE;
            grant_d   = '0;
            display_d = '0;
            busy_d    = 1'b0;
            if (pend != '0) begin
                state_d   = SERVE;
                grant_d   = win_onehot[N-1:0];
                display_d = CODE_W'(win) + CODE_W'(1);
                busy_d    = 1'b1;
                cnt_d     = CNT_LOAD;
                last_d    = win;
            end
        end
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant   <= '0;
            display <= '0;
            busy    <= 1'b0;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            display <= display_d;
            busy    <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_event_arbiter_scheduler.sv
// tb_event_arbiter_scheduler: directed stimulus pushes the expected services
// (grant, display, duration, preceding gap) into a queue; a monitor rebuilds
// each service from the outputs and pops/compares when the grant falls.
module tb_event_arbiter_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] req;
    logic       temp_en;
    logic [5:0] temperature;
    logic       rr_mode;
    logic [6:0] grant;
    logic [2:0] display;
    logic       busy;

    typedef struct {
        logic [6:0] g;
        logic [2:0] d;
        int         dur;
        int         gap;
    } svc_t;

    svc_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

    event_arbiter_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .temp_en     (temp_en),
        .temperature (temperature),
        .rr_mode     (rr_mode),
        .grant       (grant),
        .display     (display),
        .busy        (busy)
    );

    task automatic expect_svc(input logic [6:0] g, input logic [2:0] d,
                              input int dur, input int gap);
        svc_t e;
        e.g   = g;
        e.d   = d;
        e.dur = dur;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: samples 1 time unit after each rising edge and on reset assertion.
    logic [6:0] prev_g = '0;
    logic [6:0] cur_g  = '0;
    logic [2:0] cur_d  = '0;
    logic [2:0] exp_disp;
    int         dur      = 0;
    int         zeros    = 0;
    int         last_gap = -1;
    svc_t       got;

    always begin
        @(posedge clk or negedge reset_n);
        #1;
        exp_disp = '0;
        for (int i = 0; i < 7; i++) begin
            if (grant[i]) exp_disp = 3'(i + 1);
        end

        total++;
        if (!$onehot0(grant)) begin
            bad++;
            $display("FAIL onehot: grant=%b, required at most one bit set", grant);
        end
        total++;
        if (busy !== (grant != 7'd0)) begin
            bad++;
            $display("FAIL busy: busy=%b grant=%b", busy, grant);
        end
        total++;
        if (display !== exp_disp) begin
            bad++;
            $display("FAIL display: display=%0d required=%0d (grant=%b)", display, exp_disp, grant);
        end
        if (!reset_n) begin
            total++;
            if (grant !== 7'd0 || display !== 3'd0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: grant=%b display=%0d busy=%b required all 0",
                         grant, display, busy);
            end
        end

        if (grant != 7'd0 && prev_g == 7'd0) begin
            cur_g    = grant;
            cur_d    = display;
            dur      = 1;
            last_gap = zeros;
        end else if (grant != 7'd0) begin
            total++;
            if (grant != prev_g) begin
                bad++;
                $display("FAIL break_before_make: grant %b -> %b with no gap", prev_g, grant);
            end
            dur++;
        end else if (prev_g != 7'd0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_service: grant=%b display=%0d dur=%0d, required none",
                         cur_g, cur_d, dur);
            end else begin
                got = sb.pop_front();
                if (cur_g !== got.g || cur_d !== got.d || dur != got.dur ||
                    (got.gap >= 0 && last_gap != got.gap)) begin
                    bad++;
                    $display("FAIL service: got g=%b d=%0d dur=%0d gap=%0d required g=%b d=%0d dur=%0d gap=%0d",
                             cur_g, cur_d, dur, last_gap, got.g, got.d, got.dur, got.gap);
                end
            end
            zeros = 0;
        end
        if (grant == 7'd0) zeros++;
        prev_g = grant;

        if (done) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL missing_services: %0d expected services never seen, required 0", sb.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        req         = 5'b11111;
        rr_mode     = 1'b0;
        temp_en     = 1'b0;
        temperature = 6'd20;
        reset_n     = 1'b1;
        #2 reset_n  = 1'b0;
        cyc(3);

        // Reset release with all sensors requesting: bit 0 first, full dwell.
        expect_svc(7'b0000001, 3'd1, 4, -1);
        reset_n = 1'b1;
        cyc(4);
        req = 5'b00000;
        cyc(4);

        // Fixed priority: bit 2 twice with a single gap, bit 4 never served.
        expect_svc(7'b0000100, 3'd3, 4, -1);
        expect_svc(7'b0000100, 3'd3, 4, 1);
        req = 5'b10100;
        cyc(9);
        req = 5'b00000;
        cyc(4);

        // Asynchronous reset in the middle of a dwell; nothing resumes after.
        expect_svc(7'b0000010, 3'd2, 2, -1);
        req = 5'b00010;
        cyc(2);
        reset_n = 1'b0;
        req     = 5'b00000;
        cyc(2);
        reset_n = 1'b1;
        cyc(3);

        // Round-robin from reset: 0, 2, 4, 0.
        rr_mode = 1'b1;
        expect_svc(7'b0000001, 3'd1, 4, -1);
        expect_svc(7'b0000100, 3'd3, 4, 1);
        expect_svc(7'b0010000, 3'd5, 4, 1);
        expect_svc(7'b0000001, 3'd1, 4, 1);
        req = 5'b10101;
        cyc(19);
        req = 5'b00000;
        cyc(4);
        rr_mode = 1'b0;

        // Early release after two grant cycles.
        expect_svc(7'b0000010, 3'd2, 2, -1);
        req = 5'b00010;
        cyc(2);
        req = 5'b00000;
        cyc(4);

        // Heater: 9 from clear does not set; 8 sets, 9 holds, 10 clears.
        temp_en     = 1'b1;
        temperature = 6'd20;
        cyc(3);
        temperature = 6'd9;
        cyc(3);
        expect_svc(7'b0100000, 3'd6, 3, -1);
        temperature = 6'd8;
        cyc(2);
        temperature = 6'd9;
        cyc(1);
        temperature = 6'd10;
        cyc(5);

        // Cooler: 29 from clear does not set; 30 sets, 29 holds, 28 clears.
        temperature = 6'd29;
        cyc(3);
        expect_svc(7'b1000000, 3'd7, 3, -1);
        temperature = 6'd30;
        cyc(2);
        temperature = 6'd29;
        cyc(1);
        temperature = 6'd28;
        cyc(5);

        // Sensor disable clears the heater request on the next edge.
        expect_svc(7'b0100000, 3'd6, 2, -1);
        temperature = 6'd8;
        cyc(2);
        temp_en = 1'b0;
        cyc(5);
        temperature = 6'd20;

        // Lower-index request raised during a fixed-priority dwell.
        rr_mode = 1'b0;
`ifdef PREEMPT_EN
        expect_svc(7'b0001000, 3'd4, 1, -1);
        expect_svc(7'b0000001, 3'd1, 4, 1);
        req = 5'b01000;
        cyc(1);
        req = 5'b01001;
        cyc(5);
        req = 5'b00000;
`else
        expect_svc(7'b0001000, 3'd4, 4, -1);
        expect_svc(7'b0000001, 3'd1, 4, 1);
        req = 5'b01000;
        cyc(1);
        req = 5'b01001;
        cyc(8);
        req = 5'b00000;
`endif
        cyc(5);

        done = 1'b1;
        cyc(10);
        $display("FAIL monitor_stall: summary not reached after stimulus end");
        $fatal(1);
    end

endmodule

// File: doc/event_arbiter_scheduler.md
Name: event_arbiter_scheduler

Overview:
- Parametrised successor to the fixed five-sensor home-automation scan/encode/decode chain.
- Accepts NUM_CH generic sensor requests plus two internally derived temperature requests (heater, cooler) with hysteresis.
- Arbitrates the requests in fixed-priority or round-robin mode and holds each granted actuator for a programmable dwell time.
- Drives one-hot actuator outputs and a binary display code. It sits between the sensor inputs and the actuator pins, replacing the counter, priority encoder, state register and output decoder.

Parameters:
- NUM_CH, 5, number of external sensor request channels (1..14).
- TEMP_W, 6, width of unsigned temperature input.
- TEMP_LOW, 8, heater turn-on threshold (temp <= TEMP_LOW).
- TEMP_HIGH, 30, cooler turn-on threshold (temp >= TEMP_HIGH).
- HYST, 2, hysteresis band; requires TEMP_LOW+HYST < TEMP_HIGH-HYST.
- DWELL_CYCLES, 4, cycles a grant is held (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_CH  level sensor requests; bit 0 has the highest fixed priority.
- temp_en  in  1  temperature sensor enable; when 0 both temperature requests are forced clear.
- temperature  in  TEMP_W  unsigned temperature sample.
- rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration.
- grant  out  NUM_CH+2  one-hot actuator drive; bit NUM_CH = heater, bit NUM_CH+1 = cooler.
- display  out  CODE_W  served channel index+1; 0 = none. CODE_W = clog2(NUM_CH+3).
- busy  out  1  high in SERVE.

Behaviour:
- Reset (async, reset_n=0) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - heat_req = cool_req = 0;
  - last_idx = NUM_CH+1, so round-robin starts at channel 0;
  - dwell counter to 0.
- Temperature requests are registered once per cycle:
  - heat_req sets when temp_en && temperature <= TEMP_LOW; clears when temperature >= TEMP_LOW+HYST or temp_en = 0; otherwise holds.
  - cool_req sets when temp_en && temperature >= TEMP_HIGH; clears when temperature <= TEMP_HIGH-HYST or temp_en = 0; otherwise holds.
  - Both are never set together (guaranteed by the parameter constraint).
- Pending vector: P = {cool_req, heat_req, req}, width N = NUM_CH+2.
- FSM states: IDLE, SERVE, GAP.
- IDLE, P == 0: stay in IDLE; outputs 0.
- IDLE, P != 0: pick winner W.
  - rr_mode = 0: lowest set index.
  - rr_mode = 1: first set index strictly after last_idx, wrapping from N-1 to 0.
  - At the same edge: grant <= onehot(W), display <= W+1, busy <= 1, cnt <= DWELL_CYCLES-1, last_idx <= W, next state SERVE.
  - Latency: exactly one edge from request visible to grant high.
- SERVE:
  - If P[W] == 0, go to GAP at the next edge (early release).
  - Else if cnt == 0, go to GAP.
  - Else cnt <= cnt-1.
  - Grant therefore lasts DWELL_CYCLES cycles when the request is held.
- GAP: exactly one cycle with grant = 0, display = 0, busy = 0; then IDLE. This guarantees break-before-make between actuators.
- Simultaneous requests are resolved only by the arbitration rule; at most one grant bit is ever set.
- A request raised and dropped entirely within SERVE or GAP is lost. Requests are levels, not latched events.
- rr_mode changes during SERVE have no effect until the next IDLE arbitration.
- Reset mid-SERVE: all outputs clear asynchronously; no dwell resumes after reset release.

Optional Feature:
- Macro PREEMPT_EN.
- Defined: in SERVE with rr_mode = 0, any pending index lower than W aborts the dwell.
  - Next edge: GAP for one cycle, then IDLE, which grants the higher-priority channel.
  - last_idx is still updated to the aborted W.
- Undefined: a dwell always runs to completion or early release; no preemption logic is synthesised.

Decomposition:
- Package event_sched_pkg holds:
  - state enum {IDLE, SERVE, GAP};
  - function clog2;
  - function for the CODE_W derivation;
  - function returning the round-robin next-set-index given a vector and a start index.
- Sub-module temp_hysteresis (TEMP_W, TEMP_LOW, TEMP_HIGH, HYST) produces registered heat_req and cool_req.
- Arbitration and FSM stay in the top level.

Test Plan:
- Reset: reset_n=0 with req=5'b11111 -> grant=0, display=0, busy=0 during reset. First grant is bit 0 (display=1) one edge after release.
- Fixed priority, dwell: rr_mode=0, req=5'b10100 held -> grant bit2 for 4 cycles, 1 GAP cycle, bit2 again (display 3,3,3,3,0,3...). Bit 4 is never served.
- Round-robin: rr_mode=1, req=5'b10101 held -> served order 0,2,4,0 with a GAP between each; display 1,3,5,1.
- Early release: grant bit1 active, drop req[1] after 2 grant cycles -> GAP on the next edge, IDLE after that.
- Hysteresis: temp_en=1, temperature 8 -> heater bit5 requested. Temperature 9 -> still set. Temperature 10 -> cleared. Temperature 30 -> cooler bit6. Temperature 29 -> held. Temperature 28 -> cleared. temp_en=0 clears both immediately.
- PREEMPT_EN: rr_mode=0, serving bit3, raise req[0] at dwell cycle 1 -> GAP next edge, then grant bit0. Without the macro, bit3 completes 4 cycles first.
